// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the multiply/divide unit.
// Holds MDOp codes, default cycle counts and the IDLE/RUN state encoding.
package md_pkg;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MTHI  = 4'd5;
    localparam logic [3:0] MD_MTLO  = 4'd6;
    localparam logic [3:0] MD_MADD  = 4'd7;
    localparam logic [3:0] MD_MADDU = 4'd8;
    localparam logic [3:0] MD_MSUB  = 4'd9;
    localparam logic [3:0] MD_MSUBU = 4'd10;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } md_state_e;

endpackage

// File: rtl/md_unit.sv
// md_unit: EX-stage multiply/divide unit holding architectural HI/LO.
// Ports: clk, reset (async, active-high), Start, MDOp[3:0], A[31:0], B[31:0]
//        -> Busy, MD_Stall (Start|Busy), HI[31:0], LO[31:0].
// Optional: define MD_MADD_EN to build MADD/MADDU/MSUB/MSUBU accumulate.
module md_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [3:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic        MD_Stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    md_state_e   state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] phi_q, phi_d, plo_q, plo_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic        dz_q, dz_d;

    logic        is_mul, is_div, b_zero;
    logic [63:0] prod_s, prod_u, mul_res;
    logic [31:0] div_b, quo, rem;

    always_comb begin
        is_mul = 1'b0;
        is_div = 1'b0;
        unique case (MDOp)
            MD_MULT, MD_MULTU: is_mul = 1'b1;
            MD_DIV, MD_DIVU:   is_div = 1'b1;
`ifdef MD_MADD_EN
            MD_MADD, MD_MADDU,
            MD_MSUB, MD_MSUBU: is_mul = 1'b1;
`endif
            default: ;
        endcase
    end

    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};

    always_comb begin
        mul_res = prod_s;
        unique case (MDOp)
            MD_MULTU: mul_res = prod_u;
`ifdef MD_MADD_EN
            // accumulate against HI/LO as they stand at the Start edge
            MD_MADD:  mul_res = {hi_q, lo_q} + prod_s;
            MD_MADDU: mul_res = {hi_q, lo_q} + prod_u;
            MD_MSUB:  mul_res = {hi_q, lo_q} - prod_s;
            MD_MSUBU: mul_res = {hi_q, lo_q} - prod_u;
`endif
            default: ;
        endcase
    end

    // Divisor forced to 1 on zero so the divider never produces X;
    // the result is discarded via dz_q anyway.
    assign b_zero = (B == 32'd0);
    assign div_b  = b_zero ? 32'd1 : B;

    always_comb begin
        if (MDOp == MD_DIV) begin
            quo = $signed(A) / $signed(div_b);
            rem = $signed(A) % $signed(div_b);
        end else begin
            quo = A / div_b;
            rem = A % div_b;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        phi_d   = phi_q;
        plo_d   = plo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dz_d    = dz_q;
        unique case (state_q)
            S_IDLE: begin
                if (MDOp == MD_MTHI) begin
                    hi_d = A;
                end else if (MDOp == MD_MTLO) begin
                    lo_d = A;
                end else if (Start && is_mul) begin
                    {phi_d, plo_d} = mul_res;
                    dz_d    = 1'b0;
                    cnt_d   = 4'(MULT_CYCLES);
                    state_d = S_RUN;
                end else if (Start && is_div) begin
                    if (!b_zero) begin
                        phi_d = rem;
                        plo_d = quo;
                    end
                    dz_d    = b_zero;
                    cnt_d   = 4'(DIV_CYCLES);
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    if (!dz_q) begin
                        hi_d = phi_q;
                        lo_d = plo_q;
                    end
                    cnt_d   = 4'd0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            phi_q   <= 32'd0;
            plo_q   <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phi_q   <= phi_d;
            plo_q   <= plo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dz_q    <= dz_d;
        end
    end

    assign Busy     = (state_q == S_RUN);
    assign MD_Stall = Start | Busy;
    assign HI       = hi_q;
    assign LO       = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed self-checking bench for md_unit.
// Drives on negedge, samples on negedge; all expectations hand-computed.
module tb_md_unit;
    import md_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [3:0]  MDOp;
    logic [31:0] A, B;
    logic        Busy, MD_Stall;
    logic [31:0] HI, LO;

    int checks   = 0;
    int failures = 0;

    md_unit dut (
        .clk      (clk),
        .reset    (reset),
        .Start    (Start),
        .MDOp     (MDOp),
        .A        (A),
        .B        (B),
        .Busy     (Busy),
        .MD_Stall (MD_Stall),
        .HI       (HI),
        .LO       (LO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_in();
        Start = 1'b0;
        MDOp  = MD_NONE;
        A     = 32'd0;
        B     = 32'd0;
    endtask

    // Issue op at current negedge, walk n busy cycles, optionally inject
    // a stray Start/move at busy cycle inj_at; ends at negedge with Busy=0.
    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int n,
                          input logic [31:0] old_hi, input logic [31:0] old_lo,
                          input logic [31:0] new_hi, input logic [31:0] new_lo,
                          input int inj_at, input logic inj_start,
                          input logic [3:0] inj_op, input logic [31:0] inj_a);
        Start = 1'b1;
        MDOp  = op;
        A     = a;
        B     = b;
        #1;
        chk({tag, "_stall_start"}, 32'(MD_Stall), 32'd1);
        chk({tag, "_busy_start"}, 32'(Busy), 32'd0);
        @(negedge clk);
        idle_in();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_busy"}, 32'(Busy), 32'd1);
            chk({tag, "_stall"}, 32'(MD_Stall), 32'd1);
            chk({tag, "_hold_hi"}, HI, old_hi);
            chk({tag, "_hold_lo"}, LO, old_lo);
            if (i == inj_at) begin
                Start = inj_start;
                MDOp  = inj_op;
                A     = inj_a;
                B     = 32'd7;
            end else begin
                idle_in();
            end
            @(negedge clk);
        end
        idle_in();
        chk({tag, "_busy_end"}, 32'(Busy), 32'd0);
        chk({tag, "_hi"}, HI, new_hi);
        chk({tag, "_lo"}, LO, new_lo);
    endtask

    task automatic move(input string tag, input logic [3:0] op,
                        input logic [31:0] a);
        MDOp = op;
        A    = a;
        #1;
        chk({tag, "_stall"}, 32'(MD_Stall), 32'd0);
        @(negedge clk);
        idle_in();
        chk({tag, "_busy"}, 32'(Busy), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        idle_in();
        #1;
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_stall", 32'(MD_Stall), 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // -3 * 7 = -21
        run_op("mult", MD_MULT, 32'hFFFF_FFFD, 32'd7, 5,
               32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFEB,
               -1, 1'b0, MD_NONE, 32'd0);
        // back-to-back on first non-busy cycle
        run_op("divu", MD_DIVU, 32'd100, 32'd7, 10,
               32'hFFFF_FFFF, 32'hFFFF_FFEB, 32'd2, 32'd14,
               -1, 1'b0, MD_NONE, 32'd0);
        run_op("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 10,
               32'd2, 32'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
               -1, 1'b0, MD_NONE, 32'd0);

        move("mthi", MD_MTHI, 32'h1234_5678);
        chk("mthi_hi", HI, 32'h1234_5678);
        chk("mthi_lo", LO, 32'hFFFF_FFFD);

        // MTLO pulsed mid-run must be ignored
        run_op("mult_mtlo", MD_MULT, 32'd3, 32'd4, 5,
               32'h1234_5678, 32'hFFFF_FFFD, 32'd0, 32'd12,
               1, 1'b0, MD_MTLO, 32'hDEAD_BEEF);

        // stray DIV Start at busy cycle 2 must be ignored
        run_op("multu_sdiv", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,
               32'd0, 32'd12, 32'hFFFF_FFFE, 32'h0000_0001,
               2, 1'b1, MD_DIV, 32'd100);

        run_op("divz", MD_DIV, 32'd5, 32'd0, 10,
               32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFE, 32'h0000_0001,
               -1, 1'b0, MD_NONE, 32'd0);

        // async reset with counter at 4
        Start = 1'b1;
        MDOp  = MD_DIVU;
        A     = 32'd100;
        B     = 32'd7;
        @(negedge clk);
        idle_in();
        repeat (6) @(negedge clk);
        chk("rstmid_busy_pre", 32'(Busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rstmid_busy", 32'(Busy), 32'd0);
        chk("rstmid_stall", 32'(MD_Stall), 32'd0);
        chk("rstmid_hi", HI, 32'd0);
        chk("rstmid_lo", LO, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_op("mult_post", MD_MULT, 32'd6, 32'd7, 5,
               32'd0, 32'd0, 32'd0, 32'd42,
               -1, 1'b0, MD_NONE, 32'd0);

        move("mtlo", MD_MTLO, 32'hFFFF_FFFF);
        chk("mtlo_lo", LO, 32'hFFFF_FFFF);
        chk("mtlo_hi", HI, 32'd0);
`ifdef MD_MADD_EN
        run_op("maddu", MD_MADDU, 32'd1, 32'd1, 5,
               32'd0, 32'hFFFF_FFFF, 32'd1, 32'd0,
               -1, 1'b0, MD_NONE, 32'd0);
        // {1,0} - 2
        run_op("msub", MD_MSUB, 32'd1, 32'd2, 5,
               32'd1, 32'd0, 32'd0, 32'hFFFF_FFFE,
               -1, 1'b0, MD_NONE, 32'd0);
`else
        Start = 1'b1;
        MDOp  = MD_MADDU;
        A     = 32'd1;
        B     = 32'd1;
        @(negedge clk);
        idle_in();
        for (int i = 0; i < 6; i++) begin
            chk("nomadd_busy", 32'(Busy), 32'd0);
            @(negedge clk);
        end
        chk("nomadd_hi", HI, 32'd0);
        chk("nomadd_lo", LO, 32'hFFFF_FFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit for the EX stage of the 5-stage MIPS pipeline. It accepts a multiply, divide or HI/LO move from EX, runs a fixed-latency multi-cycle operation, and holds the architectural HI/LO registers. Its busy indication drives the hazard controller's global-stall input, so that a following multiply/divide or mfhi/mflo in ID is held until the result lands.

## Interface
- MULT_CYCLES, 5, cycles Busy stays high for mult/multu (and madd/msub variants)
- DIV_CYCLES, 10, cycles Busy stays high for div/divu
- clk  input  1  pipeline clock, all state on posedge
- reset  input  1  asynchronous, active-high; clears all state
- Start  input  1  EX instruction is a mult/div-class op; valid only when MDOp is a mult or div code
- MDOp  input  4  operation code (md_pkg)
- A  input  32  forwarded rs value in EX
- B  input  32  forwarded rt value in EX
- Busy  output  1  operation in flight
- MD_Stall  output  1  Start | Busy; wired to hazard controller Allstall
- HI  output  32  committed HI register
- LO  output  32  committed LO register

## Operation
- MDOp codes: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MADD=7, MADDU=8, MSUB=9, MSUBU=10; others are treated as NONE.
- States: IDLE and RUN. A 4-bit down-counter lives in RUN.
- IDLE, Start=1, mult code: latch the 64-bit result into pending regs, load counter = MULT_CYCLES, go to RUN.
- IDLE, Start=1, div code: latch quotient/remainder, load counter = DIV_CYCLES, go to RUN.
- IDLE, MTHI/MTLO: write HI/LO from A at that edge; no RUN and no Busy. Start is not required for moves.
- RUN: the counter decrements each cycle. At counter==1, commit pending to HI/LO and return to IDLE.
- Signed multiply: $signed(A)*$signed(B), 64 bits. HI=[63:32], LO=[31:0]. Unsigned multiply uses zero-extended operands.
- Signed divide: truncates toward zero. LO=quotient, HI=remainder, and the remainder takes the dividend's sign.
- Divide by zero (B==0): the full DIV_CYCLES still elapse, and HI/LO are left unchanged.
- Start or MTHI/MTLO while in RUN: ignored, with no effect on pending or HI/LO. The hazard controller guarantees this does not happen; the bench checks that it is ignored.
- Reset in any state: go to IDLE, counter=0, HI=LO=0, pending=0, Busy=0.

## Timing
- Reset values: Busy=0, MD_Stall=0, HI=0, LO=0.
- Start is sampled at edge E0.
- Busy is high from E0 to E0+N, where N is MULT_CYCLES or DIV_CYCLES.
- HI/LO take the new value at E0+N, on the same edge Busy falls.
- MD_Stall is combinational. It is high in the Start cycle and in all N Busy cycles.
- An mfhi/mflo held in ID therefore reads the correct value directly from HI/LO on the cycle after Busy falls. No HI/LO bypass is provided.
- MTHI/MTLO have 1-edge latency, and HI/LO are visible the next cycle.
- Back-to-back ops: a new Start is accepted on the first cycle Busy=0.

## Configuration
- MD_MADD_EN defined: MADD/MADDU/MSUB/MSUBU are supported.
  - At Start, pending = {HI,LO} ± product, computed from the HI/LO values at the Start edge.
  - The result commits after MULT_CYCLES.
- MD_MADD_EN undefined: codes 7–10 are decoded as NONE. Start with these codes does nothing, Busy stays 0, and no accumulate adder is built.

## Structure
- md_pkg holds:
  - MDOp localparams
  - default MULT_CYCLES/DIV_CYCLES
  - the IDLE/RUN state encoding
- Single module, no sub-module. Datapath (multiplier, divider, accumulate) and counter FSM share the pending registers.

## Test plan
- Signed multiply: reset, then MULT with A=0xFFFFFFFD, B=7. Required: Busy high for exactly 5 cycles, then HI=0xFFFFFFFF and LO=0xFFFFFFEB; MD_Stall high for 6 cycles.
- DIVU and DIV:
  - DIVU with A=100, B=7: after 10 cycles, LO=14 and HI=2.
  - DIV with A=0xFFFFFFF9 (-7), B=2: LO=0xFFFFFFFD and HI=0xFFFFFFFF.
- Moves during RUN:
  - MTHI with A=0x12345678 in IDLE: HI=0x12345678 next cycle, Busy stays 0.
  - MTLO pulsed during RUN: LO is unaffected and holds the pending result at commit.
- Start while busy and divide by zero:
  - Start MULTU with A=B=0xFFFFFFFF, then pulse Start DIV at cycle 2. Required: DIV ignored, HI=0xFFFFFFFE and LO=0x00000001 at cycle 5.
  - DIV with B=0: Busy lasts 10 cycles, HI/LO unchanged.
- Reset mid-DIVU at counter=4: Busy=0, HI=LO=0 immediately (asynchronous). A subsequent MULT then completes normally.
- MD_MADD_EN:
  - With HI=0, LO=0xFFFFFFFF, MADDU with A=1, B=1: HI=1, LO=0 after 5 cycles.
  - Without the macro: Busy stays 0 and HI/LO are unchanged.
